// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, IR capture pattern and the 1149.1 next-state function.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR      = 4'h0,
        EXIT1_DR      = 4'h1,
        SHIFT_DR      = 4'h2,
        PAUSE_DR      = 4'h3,
        SELECT_IR     = 4'h4,
        UPDATE_DR     = 4'h5,
        CAPTURE_DR    = 4'h6,
        SELECT_DR     = 4'h7,
        EXIT2_IR      = 4'h8,
        EXIT1_IR      = 4'h9,
        SHIFT_IR      = 4'hA,
        PAUSE_IR      = 4'hB,
        RUN_TEST_IDLE = 4'hC,
        UPDATE_IR     = 4'hD,
        CAPTURE_IR    = 4'hE,
        TEST_LOGIC_RST = 4'hF
    } tap_state_t;

    localparam logic [3:0] OP_EXTEST         = 4'b0000;
    localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] OP_IDCODE         = 4'b0010;
    localparam logic [3:0] OP_INTEST         = 4'b0011;
    localparam logic [3:0] OP_CLAMP          = 4'b0100;
    localparam logic [3:0] OP_BYPASS         = 4'b1111;

    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TEST_LOGIC_RST;
        case (s)
            TEST_LOGIC_RST: n = tms ? TEST_LOGIC_RST : RUN_TEST_IDLE;
            RUN_TEST_IDLE:  n = tms ? SELECT_DR      : RUN_TEST_IDLE;
            SELECT_DR:      n = tms ? SELECT_IR      : CAPTURE_DR;
            CAPTURE_DR:     n = tms ? EXIT1_DR       : SHIFT_DR;
            SHIFT_DR:       n = tms ? EXIT1_DR       : SHIFT_DR;
            EXIT1_DR:       n = tms ? UPDATE_DR      : PAUSE_DR;
            PAUSE_DR:       n = tms ? EXIT2_DR       : PAUSE_DR;
            EXIT2_DR:       n = tms ? UPDATE_DR      : SHIFT_DR;
            UPDATE_DR:      n = tms ? SELECT_DR      : RUN_TEST_IDLE;
            SELECT_IR:      n = tms ? TEST_LOGIC_RST : CAPTURE_IR;
            CAPTURE_IR:     n = tms ? EXIT1_IR       : SHIFT_IR;
            SHIFT_IR:       n = tms ? EXIT1_IR       : SHIFT_IR;
            EXIT1_IR:       n = tms ? UPDATE_IR      : PAUSE_IR;
            PAUSE_IR:       n = tms ? EXIT2_IR       : PAUSE_IR;
            EXIT2_IR:       n = tms ? UPDATE_IR      : SHIFT_IR;
            UPDATE_IR:      n = tms ? SELECT_DR      : RUN_TEST_IDLE;
            default:        n = TEST_LOGIC_RST;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; state and per-state flags are registered together on posedge tck_i.
// Flags are valid for exactly the TCK cycle spent in that state; no backpressure.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       reset_i,
    input  logic       tms_i,
    output tap_state_t o_state,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir,
    output logic       o_tlr
);

    tap_state_t r_state;
    tap_state_t w_next;
    logic       r_capture_dr;
    logic       r_shift_dr;
    logic       r_update_dr;
    logic       r_capture_ir;
    logic       r_shift_ir;
    logic       r_update_ir;
    logic       r_tlr;

    assign w_next = tap_next(r_state, tms_i);

    // Flags are computed from the next state so they line up with r_state without extra decode.
    always_ff @(posedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= TEST_LOGIC_RST;
            r_capture_dr <= 1'b0;
            r_shift_dr   <= 1'b0;
            r_update_dr  <= 1'b0;
            r_capture_ir <= 1'b0;
            r_shift_ir   <= 1'b0;
            r_update_ir  <= 1'b0;
            r_tlr        <= 1'b1;
        end else begin
            r_state      <= w_next;
            r_capture_dr <= (w_next == CAPTURE_DR);
            r_shift_dr   <= (w_next == SHIFT_DR);
            r_update_dr  <= (w_next == UPDATE_DR);
            r_capture_ir <= (w_next == CAPTURE_IR);
            r_shift_ir   <= (w_next == SHIFT_IR);
            r_update_ir  <= (w_next == UPDATE_IR);
            r_tlr        <= (w_next == TEST_LOGIC_RST);
        end
    end

    assign o_state      = r_state;
    assign o_capture_dr = r_capture_dr;
    assign o_shift_dr   = r_shift_dr;
    assign o_update_dr  = r_update_dr;
    assign o_capture_ir = r_capture_ir;
    assign o_shift_ir   = r_shift_ir;
    assign o_update_ir  = r_update_ir;
    assign o_tlr        = r_tlr;

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP: IR, BYPASS/IDCODE/boundary-scan DRs, TDO mux and instruction decode. IDCODE DR under JTAG_IDCODE_EN.
// TDO follows the shift edge by half a TCK; bypass latency 1 TCK, BSR latency BSR_WIDTH TCK; no backpressure.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter int          BSR_WIDTH    = 26,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                 tck_i,
    input  logic                 reset_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe_o,
    input  logic [BSR_WIDTH-1:0] capture_data_i,
    output logic [BSR_WIDTH-1:0] update_data_o,
    output logic                 update_o,
    output logic                 ir_extest_o,
    output logic                 ir_sample_preload_o,
    output logic                 ir_intest_o,
    output logic                 ir_clamp_o,
    output logic                 ir_bypass_o,
    output logic                 ir_idcode_o
);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OP_BYPASS);
`endif

    if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_chk
        $error("IDCODE_VALUE bit 0 must be 1");
    end

    tap_state_t w_state;
    logic       w_capture_dr;
    logic       w_shift_dr;
    logic       w_update_dr;
    logic       w_capture_ir;
    logic       w_shift_ir;
    logic       w_update_ir;
    logic       w_tlr;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .reset_i      (reset_i),
        .tms_i        (tms_i),
        .o_state      (w_state),
        .o_capture_dr (w_capture_dr),
        .o_shift_dr   (w_shift_dr),
        .o_update_dr  (w_update_dr),
        .o_capture_ir (w_capture_ir),
        .o_shift_ir   (w_shift_ir),
        .o_update_ir  (w_update_ir),
        .o_tlr        (w_tlr)
    );

    logic [IR_WIDTH-1:0]  r_ir_shift;
    logic [IR_WIDTH-1:0]  r_ir_active;
    logic [BSR_WIDTH-1:0] r_bsr;
    logic                 r_bypass;
    logic                 r_tdo;
    logic                 r_tdo_oe;

    logic w_is_extest;
    logic w_is_sample;
    logic w_is_intest;
    logic w_is_clamp;
    logic w_sel_bsr;
    logic w_sel_idcode;
    logic w_sel_bypass;
    logic w_idcode_tdo;
    logic w_dr_tdo;

    assign w_is_extest  = (r_ir_active == IR_WIDTH'(OP_EXTEST));
    assign w_is_sample  = (r_ir_active == IR_WIDTH'(OP_SAMPLE_PRELOAD));
    assign w_is_intest  = (r_ir_active == IR_WIDTH'(OP_INTEST));
    assign w_is_clamp   = (r_ir_active == IR_WIDTH'(OP_CLAMP));
    assign w_sel_bsr    = w_is_extest | w_is_sample | w_is_intest;
    // Anything not claiming the BSR or IDCODE falls back to the 1-bit bypass path.
    assign w_sel_bypass = ~w_sel_bsr & ~w_sel_idcode;

    always_ff @(posedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_ir_shift <= '0;
        end else if (w_capture_ir) begin
            r_ir_shift <= IR_WIDTH'(IR_CAPTURE);
        end else if (w_shift_ir) begin
            r_ir_shift <= {tdi_i, r_ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Active IR moves on the falling edge so decodes are stable across the following rising edge.
    always_ff @(negedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_ir_active <= IR_RESET;
        end else if (w_tlr) begin
            r_ir_active <= IR_RESET;
        end else if (w_update_ir) begin
            r_ir_active <= r_ir_shift;
        end
    end

    always_ff @(posedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_bsr <= '0;
        end else if (w_capture_dr && w_sel_bsr) begin
            r_bsr <= capture_data_i;
        end else if (w_shift_dr && w_sel_bsr) begin
            r_bsr <= {tdi_i, r_bsr[BSR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_bypass <= 1'b0;
        end else if (w_capture_dr && w_sel_bypass) begin
            r_bypass <= 1'b0;
        end else if (w_shift_dr && w_sel_bypass) begin
            r_bypass <= tdi_i;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] r_idcode;

    always_ff @(posedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_idcode <= '0;
        end else if (w_capture_dr && w_sel_idcode) begin
            r_idcode <= IDCODE_VALUE;
        end else if (w_shift_dr && w_sel_idcode) begin
            r_idcode <= {tdi_i, r_idcode[31:1]};
        end
    end

    assign w_sel_idcode = (r_ir_active == IR_WIDTH'(OP_IDCODE));
    assign w_idcode_tdo = r_idcode[0];
`else
    assign w_sel_idcode = 1'b0;
    assign w_idcode_tdo = 1'b0;
`endif

    assign w_dr_tdo = w_sel_bsr    ? r_bsr[0] :
                      w_sel_idcode ? w_idcode_tdo :
                                     r_bypass;

    always_ff @(negedge tck_i or posedge reset_i) begin
        if (reset_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo_oe <= (w_state == SHIFT_DR) || (w_state == SHIFT_IR);
            r_tdo    <= w_shift_ir ? r_ir_shift[0] :
                        w_shift_dr ? w_dr_tdo      : 1'b0;
        end
    end

    assign tdo_o               = r_tdo;
    assign tdo_oe_o            = r_tdo_oe;
    assign update_data_o       = r_bsr;
    assign update_o            = w_update_dr & w_sel_bsr;
    assign ir_extest_o         = w_is_extest;
    assign ir_sample_preload_o = w_is_sample;
    assign ir_intest_o         = w_is_intest;
    assign ir_clamp_o          = w_is_clamp;
    assign ir_bypass_o         = w_sel_bypass & ~w_is_clamp;
    assign ir_idcode_o         = w_sel_idcode;

endmodule
